// File: rtl/ctrl_seq_mc.sv
// Multi-cycle fetch/execute/memop control sequencer with a MemRdy handshake for the basic datapath.
// Defining CTRL_TIMEOUT_EN adds a bus-timeout fault that traps in FAULT until Reset_n_i.
module ctrl_seq_mc #(
    parameter int INSTR_W     = 32,
    parameter int OPC_W       = 6,
    parameter int REG_AW      = 5,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic               Clk_i,
    input  logic               Reset_n_i,
    input  logic [INSTR_W-1:0] Instr_i,
    input  logic               ZE_i,
    input  logic               NG_i,
    input  logic               CY_i,
    input  logic               OV_i,
    input  logic               MemRdy_i,
    output logic [REG_AW-1:0]  AddrA_o,
    output logic [REG_AW-1:0]  AddrB_o,
    output logic [REG_AW-1:0]  AddrC_o,
    output logic [3:0]         ALUOp_o,
    output logic               WrC_o,
    output logic               WrPC_o,
    output logic               WrCR_o,
    output logic               WrIR_o,
    output logic               Mem_ALU_o,
    output logic               PC_RA_o,
    output logic               IR_RB_o,
    output logic               ALU_PC_o,
    output logic               ZE_SE_o,
    output logic               Sin_Sout_o,
    output logic               MemRd_o,
    output logic               MemWr_o,
    output logic               MemLength_o,
    output logic               MemEnable_o,
    output logic [2:0]         Status_o,
    output logic               Illegal_o,
    output logic               Retire_o,
    output logic               Fault_o
);

    typedef enum logic [2:0] {
        P_RESET    = 3'd0,
        FETCH      = 3'd1,
        EXECUTE    = 3'd2,
        MEMOP      = 3'd3,
        FETCH_WAIT = 3'd4,
        FAULT      = 3'd7
    } StateT;

    localparam logic [OPC_W-1:0] OP_ADDI   = OPC_W'(6'b010001);
    localparam logic [OPC_W-1:0] OP_REG    = OPC_W'(6'b011000);
    localparam logic [OPC_W-3:0] OP_MEM_HI = (OPC_W-2)'(4'b1000);
    localparam logic [3:0]       ALU_INC   = 4'b1110;
    localparam logic [3:0]       ALU_ADD   = 4'b0001;
    localparam logic [3:0]       ALU_REG   = 4'b0110;

    StateT state_q, state_d;

    logic [OPC_W-1:0]  opcode;
    logic [REG_AW-1:0] fieldC;
    logic [REG_AW-1:0] fieldA;
    logic [REG_AW-1:0] fieldB;
    logic              isAddi;
    logic              isReg;
    logic              isMem;
    logic              isStore;
    logic              timeoutHit;

    // Flags are reserved for future branches; low IR bits belong to the immediate.
    logic unusedInputs;
    assign unusedInputs = ^{ZE_i, NG_i, CY_i, OV_i, Instr_i};

    assign opcode  = Instr_i[INSTR_W-1 -: OPC_W];
    assign fieldC  = Instr_i[INSTR_W-OPC_W-1 -: REG_AW];
    assign fieldA  = Instr_i[INSTR_W-OPC_W-REG_AW-1 -: REG_AW];
    assign fieldB  = Instr_i[INSTR_W-OPC_W-2*REG_AW-1 -: REG_AW];
    assign isAddi  = (opcode == OP_ADDI);
    assign isReg   = (opcode == OP_REG);
    assign isMem   = (opcode[OPC_W-1:2] == OP_MEM_HI);
    assign isStore = isMem & opcode[1];

`ifdef CTRL_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] waitCnt_q, waitCnt_d;
    logic             waiting;

    // Counter is held at zero outside the wait states, so it is clear on every entry.
    assign waiting    = (state_q == FETCH_WAIT) || (state_q == MEMOP);
    assign waitCnt_d  = (waiting && !MemRdy_i) ? waitCnt_q + 1'b1 : '0;
    assign timeoutHit = waiting && !MemRdy_i && (waitCnt_d == CNT_W'(TIMEOUT_CYC));

    always_ff @(posedge Clk_i or negedge Reset_n_i) begin
        if (!Reset_n_i) begin
            waitCnt_q <= '0;
        end else begin
            waitCnt_q <= waitCnt_d;
        end
    end
`else
    logic unusedTimeout;
    assign unusedTimeout = (TIMEOUT_CYC != 0);
    assign timeoutHit    = 1'b0;
`endif

    always_ff @(posedge Clk_i or negedge Reset_n_i) begin
        if (!Reset_n_i) begin
            state_q <= P_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    // Outputs are decoded from state and opcode; WrIR/WrPC/WrC also follow MemRdy_i in the same cycle.
    always_comb begin
        state_d     = state_q;
        AddrA_o     = '0;
        AddrB_o     = '0;
        AddrC_o     = '0;
        ALUOp_o     = 4'b0000;
        WrC_o       = 1'b0;
        WrPC_o      = 1'b0;
        WrCR_o      = 1'b0;
        WrIR_o      = 1'b0;
        Mem_ALU_o   = 1'b0;
        PC_RA_o     = 1'b0;
        IR_RB_o     = 1'b0;
        ALU_PC_o    = 1'b0;
        ZE_SE_o     = 1'b0;
        Sin_Sout_o  = 1'b0;
        MemRd_o     = 1'b0;
        MemWr_o     = 1'b0;
        MemLength_o = 1'b0;
        MemEnable_o = 1'b0;
        Illegal_o   = 1'b0;
        Retire_o    = 1'b0;
        Fault_o     = 1'b0;
        Status_o    = state_q;

        case (state_q)
            P_RESET: begin
                state_d = FETCH;
            end

            FETCH, FETCH_WAIT: begin
                MemEnable_o = 1'b1;
                MemRd_o     = 1'b1;
                MemLength_o = 1'b1;
                ALU_PC_o    = 1'b1;
                ALUOp_o     = ALU_INC;
                if (state_q == FETCH) begin
                    state_d = FETCH_WAIT;
                end else if (MemRdy_i) begin
                    WrIR_o  = 1'b1;
                    WrPC_o  = 1'b1;
                    state_d = EXECUTE;
                end else if (timeoutHit) begin
                    state_d = FAULT;
                end
            end

            EXECUTE: begin
                AddrC_o = fieldC;
                AddrA_o = fieldA;
                state_d = FETCH;
                if (isAddi) begin
                    PC_RA_o   = 1'b1;
                    ZE_SE_o   = 1'b1;
                    ALUOp_o   = ALU_ADD;
                    Mem_ALU_o = 1'b1;
                    WrC_o     = 1'b1;
                    WrCR_o    = 1'b1;
                    Retire_o  = 1'b1;
                end else if (isReg) begin
                    AddrB_o   = fieldB;
                    PC_RA_o   = 1'b1;
                    IR_RB_o   = 1'b1;
                    ALUOp_o   = ALU_REG;
                    Mem_ALU_o = 1'b1;
                    WrC_o     = 1'b1;
                    WrCR_o    = 1'b1;
                    Retire_o  = 1'b1;
                end else if (isMem) begin
                    AddrB_o = isStore ? fieldC : '0;
                    PC_RA_o = 1'b1;
                    ZE_SE_o = 1'b1;
                    ALUOp_o = ALU_ADD;
                    state_d = MEMOP;
                end else begin
                    Illegal_o = 1'b1;
                    Retire_o  = 1'b1;
                end
            end

            // Only load/store opcodes reach MEMOP, and IR cannot change until the next fetch.
            MEMOP: begin
                AddrC_o     = fieldC;
                AddrA_o     = fieldA;
                AddrB_o     = isStore ? fieldC : '0;
                PC_RA_o     = 1'b1;
                ZE_SE_o     = 1'b1;
                ALUOp_o     = ALU_ADD;
                MemEnable_o = 1'b1;
                MemLength_o = opcode[0];
                MemRd_o     = ~isStore;
                MemWr_o     = isStore;
                Sin_Sout_o  = isStore;
                if (MemRdy_i) begin
                    WrC_o    = ~isStore;
                    Retire_o = 1'b1;
                    state_d  = FETCH;
                end else if (timeoutHit) begin
                    state_d = FAULT;
                end
            end

            FAULT: begin
                Fault_o = 1'b1;
            end

            default: begin
                state_d = P_RESET;
            end
        endcase
    end

endmodule

// File: tb/tb_ctrl_seq_mc.sv
// Self-checking bench for ctrl_seq_mc: directed scenarios plus a randomized instruction stream
// checked against a per-instruction cycle trace model. Timeout scenarios follow CTRL_TIMEOUT_EN.
module tb_ctrl_seq_mc;

    localparam logic [13:0] M_WRC    = 14'h2000;
    localparam logic [13:0] M_WRPC   = 14'h1000;
    localparam logic [13:0] M_WRCR   = 14'h0800;
    localparam logic [13:0] M_WRIR   = 14'h0400;
    localparam logic [13:0] M_MEMALU = 14'h0200;
    localparam logic [13:0] M_PCRA   = 14'h0100;
    localparam logic [13:0] M_IRRB   = 14'h0080;
    localparam logic [13:0] M_ALUPC  = 14'h0040;
    localparam logic [13:0] M_ZESE   = 14'h0020;
    localparam logic [13:0] M_SIN    = 14'h0010;
    localparam logic [13:0] M_MEMRD  = 14'h0008;
    localparam logic [13:0] M_MEMWR  = 14'h0004;
    localparam logic [13:0] M_MEMLEN = 14'h0002;
    localparam logic [13:0] M_MEMEN  = 14'h0001;
    localparam logic [13:0] FETCH_CTL = M_MEMEN | M_MEMRD | M_MEMLEN | M_ALUPC;

    typedef struct {
        logic [2:0]  status;
        logic        rdy;
        logic [3:0]  aluOp;
        logic [4:0]  addrA;
        logic [4:0]  addrB;
        logic [4:0]  addrC;
        logic [13:0] ctl;
        logic        illegal;
        logic        retire;
    } ExpCycle;

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic [31:0] instr = '0;
    logic        ze = 1'b0, ng = 1'b0, cy = 1'b0, ov = 1'b0;
    logic        memRdy = 1'b0;
    logic [4:0]  addrA, addrB, addrC;
    logic [3:0]  aluOp;
    logic        wrC, wrPC, wrCR, wrIR;
    logic        memALU, pcRA, irRB, aluPC, zeSE, sinSout;
    logic        memRd, memWr, memLength, memEnable;
    logic [2:0]  status;
    logic        illegal, retire, fault;
    logic [13:0] ctlObs;

    int checkCount = 0;
    int passCount  = 0;
    ExpCycle trace[$];

    assign ctlObs = {wrC, wrPC, wrCR, wrIR, memALU, pcRA, irRB, aluPC, zeSE, sinSout,
                     memRd, memWr, memLength, memEnable};

    ctrl_seq_mc dut (
        .Clk_i(clk), .Reset_n_i(resetN), .Instr_i(instr),
        .ZE_i(ze), .NG_i(ng), .CY_i(cy), .OV_i(ov), .MemRdy_i(memRdy),
        .AddrA_o(addrA), .AddrB_o(addrB), .AddrC_o(addrC), .ALUOp_o(aluOp),
        .WrC_o(wrC), .WrPC_o(wrPC), .WrCR_o(wrCR), .WrIR_o(wrIR),
        .Mem_ALU_o(memALU), .PC_RA_o(pcRA), .IR_RB_o(irRB), .ALU_PC_o(aluPC),
        .ZE_SE_o(zeSE), .Sin_Sout_o(sinSout),
        .MemRd_o(memRd), .MemWr_o(memWr), .MemLength_o(memLength), .MemEnable_o(memEnable),
        .Status_o(status), .Illegal_o(illegal), .Retire_o(retire), .Fault_o(fault)
    );

    always #5 clk = ~clk;

    // Hard time limit so a stuck run still terminates.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Leaves the DUT in its first FETCH cycle.
    task automatic resetDut();
        resetN = 1'b0;
        memRdy = 1'b0;
        nextCycle();
        nextCycle();
        resetN = 1'b1;
        nextCycle();
    endtask

    // From a FETCH cycle, completes a zero-wait fetch and stops in EXECUTE.
    task automatic skipFetch();
        memRdy = 1'b1;
        nextCycle();
        nextCycle();
    endtask

    // Reference model: expected cycle-by-cycle behaviour of one instruction.
    task automatic buildTrace(input logic [31:0] ins, input int fw, input int mw);
        ExpCycle e;
        logic [5:0] opc;
        bit isMem;
        opc   = ins[31:26];
        isMem = (opc[5:2] == 4'b1000);
        e = '{default: '0};
        e.status = 3'd1;
        e.rdy    = 1'($urandom);
        e.aluOp  = 4'b1110;
        e.ctl    = FETCH_CTL;
        trace.push_back(e);
        for (int i = 0; i <= fw; i++) begin
            e.status = 3'd4;
            e.rdy    = (i == fw);
            e.ctl    = FETCH_CTL | ((i == fw) ? (M_WRIR | M_WRPC) : 14'h0);
            trace.push_back(e);
        end
        e = '{default: '0};
        e.status = 3'd2;
        e.rdy    = 1'($urandom);
        e.addrC  = ins[25:21];
        e.addrA  = ins[20:16];
        if (opc == 6'b010001) begin
            e.aluOp  = 4'b0001;
            e.ctl    = M_PCRA | M_ZESE | M_MEMALU | M_WRC | M_WRCR;
            e.retire = 1'b1;
        end else if (opc == 6'b011000) begin
            e.aluOp  = 4'b0110;
            e.addrB  = ins[15:11];
            e.ctl    = M_PCRA | M_IRRB | M_MEMALU | M_WRC | M_WRCR;
            e.retire = 1'b1;
        end else if (isMem) begin
            e.aluOp = 4'b0001;
            e.addrB = opc[1] ? ins[25:21] : 5'd0;
            e.ctl   = M_PCRA | M_ZESE;
        end else begin
            e.illegal = 1'b1;
            e.retire  = 1'b1;
        end
        trace.push_back(e);
        if (isMem) begin
            for (int i = 0; i <= mw; i++) begin
                e.status = 3'd3;
                e.rdy    = (i == mw);
                e.ctl    = M_PCRA | M_ZESE | M_MEMEN | (opc[0] ? M_MEMLEN : 14'h0) |
                           (opc[1] ? (M_MEMWR | M_SIN) : M_MEMRD);
                e.retire = (i == mw);
                if (i == mw && !opc[1]) e.ctl = e.ctl | M_WRC;
                trace.push_back(e);
            end
        end
    endtask

    task automatic test_reset();
        resetN = 1'b0;
        memRdy = 1'b1;
        instr  = {6'b010001, 5'd3, 5'd2, 16'h0};
        for (int i = 0; i < 3; i++) begin
            nextCycle();
            checkCount++;
            if ({status, ctlObs, aluOp, addrA, addrB, addrC, illegal, retire, fault} !== '0)
                $display("[TB] FAIL reset_outputs: status=%0d ctl=%h alu=%h got nonzero, expected all 0",
                         status, ctlObs, aluOp);
            else passCount++;
        end
        nextCycle();
        resetN = 1'b1;
        #1;
        checkCount++;
        if (status !== 3'd0) $display("[TB] FAIL reset_release_status: got %0d expected 0", status);
        else passCount++;
        nextCycle();
        checkCount++;
        if ({status, ctlObs} !== {3'd1, FETCH_CTL})
            $display("[TB] FAIL fetch: status=%0d ctl=%h expected status=1 ctl=%h", status, ctlObs, FETCH_CTL);
        else passCount++;
        nextCycle();
        checkCount++;
        if ({status, ctlObs} !== {3'd4, FETCH_CTL | M_WRIR | M_WRPC})
            $display("[TB] FAIL fetch_wait: status=%0d ctl=%h expected status=4 ctl=%h",
                     status, ctlObs, FETCH_CTL | M_WRIR | M_WRPC);
        else passCount++;
        nextCycle();
        checkCount++;
        if ({status, wrIR, wrPC} !== {3'd2, 2'b00})
            $display("[TB] FAIL execute_entry: status=%0d wrIR=%b wrPC=%b expected 2,0,0", status, wrIR, wrPC);
        else passCount++;
    endtask

    task automatic test_imm_add();
        resetDut();
        instr  = {6'b010001, 5'd3, 5'd2, 16'hBEEF};
        memRdy = 1'b0;
        nextCycle();
        for (int i = 0; i < 4; i++) begin
            #1;
            checkCount++;
            if ({status, wrIR, wrPC} !== {3'd4, 2'b00})
                $display("[TB] FAIL imm_wait%0d: status=%0d wrIR=%b expected 4,0", i, status, wrIR);
            else passCount++;
            nextCycle();
        end
        memRdy = 1'b1;
        #1;
        checkCount++;
        if ({wrIR, wrPC} !== 2'b11) $display("[TB] FAIL imm_wrir: got %b expected 11", {wrIR, wrPC});
        else passCount++;
        nextCycle();
        memRdy = 1'b0;
        #1;
        checkCount++;
        if ({status, addrC, addrA, aluOp, ctlObs, retire, illegal} !==
            {3'd2, 5'd3, 5'd2, 4'b0001, M_PCRA | M_ZESE | M_MEMALU | M_WRC | M_WRCR, 1'b1, 1'b0})
            $display("[TB] FAIL imm_exec: status=%0d C=%0d A=%0d alu=%h ctl=%h ret=%b expected 2,3,2,1,%h,1",
                     status, addrC, addrA, aluOp, ctlObs, retire, M_PCRA | M_ZESE | M_MEMALU | M_WRC | M_WRCR);
        else passCount++;
        nextCycle();
        checkCount++;
        if ({status, retire} !== {3'd1, 1'b0})
            $display("[TB] FAIL imm_back_to_fetch: status=%0d retire=%b expected 1,0", status, retire);
        else passCount++;
    endtask

    task automatic test_load();
        logic [13:0] base;
        resetDut();
        instr = {6'b100001, 5'd5, 5'd6, 16'h0010};
        base  = M_PCRA | M_ZESE | M_MEMEN | M_MEMLEN | M_MEMRD;
        skipFetch();
        memRdy = 1'b0;
        nextCycle();
        for (int i = 0; i < 3; i++) begin
            memRdy = (i == 2);
            #1;
            checkCount++;
            if ({status, ctlObs, retire} !== {3'd3, (i == 2) ? (base | M_WRC) : base, i == 2})
                $display("[TB] FAIL load_memop%0d: status=%0d ctl=%h ret=%b expected 3,%h,%0d",
                         i, status, ctlObs, retire, (i == 2) ? (base | M_WRC) : base, i == 2);
            else passCount++;
            nextCycle();
        end
        checkCount++;
        if ({status, wrC} !== {3'd1, 1'b0}) $display("[TB] FAIL load_done: status=%0d wrC=%b expected 1,0", status, wrC);
        else passCount++;
        instr = {6'b100000, 5'd5, 5'd6, 16'h0010};
        skipFetch();
        nextCycle();
        checkCount++;
        if ({status, memLength, wrC, retire} !== {3'd3, 3'b011})
            $display("[TB] FAIL byte_load: status=%0d len=%b wrC=%b ret=%b expected 3,0,1,1",
                     status, memLength, wrC, retire);
        else passCount++;
    endtask

    task automatic test_store();
        logic [13:0] exp;
        resetDut();
        instr = {6'b100010, 5'd7, 5'd9, 5'd12, 11'h0};
        exp   = M_PCRA | M_ZESE | M_MEMEN | M_MEMWR | M_SIN;
        skipFetch();
        memRdy = 1'b0;
        nextCycle();
        #1;
        checkCount++;
        if ({status, ctlObs, addrB, addrC} !== {3'd3, exp, 5'd7, 5'd7})
            $display("[TB] FAIL store_wait: status=%0d ctl=%h B=%0d C=%0d expected 3,%h,7,7",
                     status, ctlObs, addrB, addrC, exp);
        else passCount++;
        nextCycle();
        memRdy = 1'b1;
        #1;
        checkCount++;
        if ({ctlObs, retire} !== {exp, 1'b1})
            $display("[TB] FAIL store_done: ctl=%h ret=%b expected %h,1", ctlObs, retire, exp);
        else passCount++;
        nextCycle();
        checkCount++;
        if ({status, sinSout, memWr} !== {3'd1, 2'b00})
            $display("[TB] FAIL store_after: status=%0d sin=%b wr=%b expected 1,0,0", status, sinSout, memWr);
        else passCount++;
    endtask

    task automatic test_illegal_and_async_reset();
        resetDut();
        instr = 32'hFFFF_FFFF;
        skipFetch();
        #1;
        checkCount++;
        if ({illegal, retire, wrC, wrCR, wrPC, wrIR} !== 6'b110000)
            $display("[TB] FAIL illegal_exec: got %b expected 110000", {illegal, retire, wrC, wrCR, wrPC, wrIR});
        else passCount++;
        nextCycle();
        checkCount++;
        if ({status, illegal} !== {3'd1, 1'b0}) $display("[TB] FAIL illegal_pulse: status=%0d ill=%b expected 1,0", status, illegal);
        else passCount++;
        instr = {6'b100001, 5'd1, 5'd2, 16'h0};
        nextCycle();
        nextCycle();
        checkCount++;
        if (status !== 3'd2) $display("[TB] FAIL illegal_next_fetch: status=%0d expected 2", status);
        else passCount++;
        memRdy = 1'b0;
        nextCycle();
        #1;
        resetN = 1'b0;
        #1;
        checkCount++;
        if ({status, memEnable, memRd, memWr} !== {3'd0, 3'b000})
            $display("[TB] FAIL async_reset_memop: status=%0d en=%b rd=%b wr=%b expected 0,0,0,0",
                     status, memEnable, memRd, memWr);
        else passCount++;
        nextCycle();
        resetN = 1'b1;
    endtask

    task automatic test_random();
        ExpCycle e;
        logic [31:0] ins;
        int pick;
        resetDut();
        for (int n = 0; n < 60; n++) begin
            ins  = $urandom;
            pick = $urandom_range(0, 5);
            case (pick)
                0: ins[31:26] = 6'b010001;
                1: ins[31:26] = 6'b011000;
                2: ins[31:26] = {4'b1000, 1'b0, 1'($urandom)};
                3: ins[31:26] = {4'b1000, 1'b1, 1'($urandom)};
                default: ins[31:26] = 6'($urandom);
            endcase
            buildTrace(ins, $urandom_range(0, 3), $urandom_range(0, 3));
            instr = ins;
            while (trace.size() > 0) begin
                e = trace.pop_front();
                memRdy = e.rdy;
                {ze, ng, cy, ov} = 4'($urandom);
                #1;
                checkCount++;
                if ({status, aluOp, addrA, addrB, addrC, ctlObs, illegal, retire, fault} !==
                    {e.status, e.aluOp, e.addrA, e.addrB, e.addrC, e.ctl, e.illegal, e.retire, 1'b0})
                    $display("[TB] FAIL random instr=%h: st=%0d alu=%h A=%0d B=%0d C=%0d ctl=%h il=%b rt=%b f=%b expected st=%0d alu=%h A=%0d B=%0d C=%0d ctl=%h il=%b rt=%b f=0",
                             ins, status, aluOp, addrA, addrB, addrC, ctlObs, illegal, retire, fault,
                             e.status, e.aluOp, e.addrA, e.addrB, e.addrC, e.ctl, e.illegal, e.retire);
                else passCount++;
                nextCycle();
            end
        end
    endtask

`ifdef CTRL_TIMEOUT_EN
    task automatic test_timeout();
        resetDut();
        instr = {6'b100001, 5'd4, 5'd8, 16'h0};
        skipFetch();
        memRdy = 1'b0;
        nextCycle();
        for (int i = 0; i < 15; i++) begin
            checkCount++;
            if ({status, fault} !== {3'd3, 1'b0})
                $display("[TB] FAIL timeout_wait%0d: status=%0d fault=%b expected 3,0", i, status, fault);
            else passCount++;
            nextCycle();
        end
        for (int i = 0; i < 4; i++) begin
            memRdy = 1'($urandom);
            #1;
            checkCount++;
            if ({status, fault, ctlObs} !== {3'd7, 1'b1, 14'h0})
                $display("[TB] FAIL timeout_fault%0d: status=%0d fault=%b ctl=%h expected 7,1,0", i, status, fault, ctlObs);
            else passCount++;
            nextCycle();
        end
        resetDut();
        checkCount++;
        if ({status, fault} !== {3'd1, 1'b0}) $display("[TB] FAIL fault_cleared: status=%0d fault=%b expected 1,0", status, fault);
        else passCount++;
        skipFetch();
        memRdy = 1'b0;
        nextCycle();
        for (int i = 0; i < 14; i++) nextCycle();
        memRdy = 1'b1;
        #1;
        checkCount++;
        if ({status, wrC, retire, fault} !== {3'd3, 3'b110})
            $display("[TB] FAIL timeout_tie: status=%0d wrC=%b ret=%b fault=%b expected 3,1,1,0", status, wrC, retire, fault);
        else passCount++;
        nextCycle();
        checkCount++;
        if (status !== 3'd1) $display("[TB] FAIL timeout_tie_next: status=%0d expected 1", status);
        else passCount++;
    endtask
`else
    task automatic test_no_timeout();
        resetDut();
        instr = {6'b100001, 5'd4, 5'd8, 16'h0};
        skipFetch();
        memRdy = 1'b0;
        nextCycle();
        for (int i = 0; i < 40; i++) nextCycle();
        checkCount++;
        if ({status, fault, memEnable} !== {3'd3, 1'b0, 1'b1})
            $display("[TB] FAIL long_wait: status=%0d fault=%b en=%b expected 3,0,1", status, fault, memEnable);
        else passCount++;
        memRdy = 1'b1;
        #1;
        checkCount++;
        if ({wrC, retire} !== 2'b11) $display("[TB] FAIL long_wait_done: got %b expected 11", {wrC, retire});
        else passCount++;
        nextCycle();
    endtask
`endif

    initial begin
        test_reset();
        test_imm_add();
        test_load();
        test_store();
        test_illegal_and_async_reset();
        test_random();
`ifdef CTRL_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
